// File: rtl/rip_branch_target_buffer.sv
// Direct-mapped branch target buffer: 1-cycle registered lookup, execute-stage write-back, bulk invalidate.
// Optional same-cycle update-to-lookup forwarding is enabled with `define RIP_BTB_BYPASS_EN.
module rip_branch_target_buffer #(
  parameter int BTB_ENTRIES = 64,
  parameter int INDEX_WIDTH = $clog2(BTB_ENTRIES),
  parameter int TAG_WIDTH   = 30 - INDEX_WIDTH
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        lookup_valid,
  input  logic [31:0] lookup_pc,
  output logic        hit,
  output logic [31:0] target,
  input  logic        update_valid,
  input  logic [31:0] update_pc,
  input  logic        update_taken,
  input  logic [31:0] update_target,
  input  logic        invalidate
);

  logic [BTB_ENTRIES-1:0] valid_q;
  logic [TAG_WIDTH-1:0]   tag_q [BTB_ENTRIES];
  logic [29:0]            tgt_q [BTB_ENTRIES];

  logic [INDEX_WIDTH-1:0] lk_idx;
  logic [INDEX_WIDTH-1:0] up_idx;
  logic [TAG_WIDTH-1:0]   lk_tag;
  logic [TAG_WIDTH-1:0]   up_tag;
  logic                   lk_match;
  logic                   up_match;
  logic                   wr_taken;
  logic                   clr_not_taken;
  logic                   hit_d;
  logic [29:0]            tgt_d;
  logic [31:0]            target_d;
  logic                   unused_low_bits;

  assign lk_idx = lookup_pc[INDEX_WIDTH+1:2];
  assign lk_tag = lookup_pc[31:INDEX_WIDTH+2];
  assign up_idx = update_pc[INDEX_WIDTH+1:2];
  assign up_tag = update_pc[31:INDEX_WIDTH+2];

  // PC and target bits [1:0] carry no information for word-aligned fetch.
  assign unused_low_bits = ^{lookup_pc[1:0], update_pc[1:0], update_target[1:0]};

  assign lk_match = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
  assign up_match = valid_q[up_idx] && (tag_q[up_idx] == up_tag);

  // invalidate wins over any concurrent update, which is simply dropped.
  assign wr_taken      = update_valid && update_taken && !invalidate;
  assign clr_not_taken = update_valid && !update_taken && !invalidate && up_match;

  always_comb begin
    hit_d = lookup_valid && lk_match;
    tgt_d = tgt_q[lk_idx];
`ifdef RIP_BTB_BYPASS_EN
    // Present the lookup with the table as it will look after this edge.
    if (lookup_valid && update_valid && (up_idx == lk_idx)) begin
      if (update_taken) begin
        hit_d = (up_tag == lk_tag);
        tgt_d = update_target[31:2];
      end else if (up_tag == lk_tag) begin
        hit_d = 1'b0;
      end
    end
    if (invalidate) begin
      hit_d = 1'b0;
    end
`endif
    target_d = hit_d ? {tgt_d, 2'b00} : 32'h0;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      hit    <= 1'b0;
      target <= 32'h0;
    end else begin
      hit    <= hit_d;
      target <= target_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      valid_q <= '0;
    end else if (invalidate) begin
      valid_q <= '0;
    end else if (wr_taken) begin
      valid_q[up_idx] <= 1'b1;
    end else if (clr_not_taken) begin
      valid_q[up_idx] <= 1'b0;
    end
  end

  // Tag/target storage has no reset so it can map onto distributed RAM.
  always_ff @(posedge clk) begin
    if (rstn && wr_taken) begin
      tag_q[up_idx] <= up_tag;
      tgt_q[up_idx] <= update_target[31:2];
    end
  end

endmodule

// File: tb/tb_rip_branch_target_buffer.sv
// Directed bench for rip_branch_target_buffer (64 entries); expectations follow RIP_BTB_BYPASS_EN if defined.
module tb_rip_branch_target_buffer;

  logic        clk;
  logic        rstn;
  logic        lookup_valid;
  logic [31:0] lookup_pc;
  logic        hit;
  logic [31:0] target;
  logic        update_valid;
  logic [31:0] update_pc;
  logic        update_taken;
  logic [31:0] update_target;
  logic        invalidate;

  int total = 0;
  int bad   = 0;

  rip_branch_target_buffer #(.BTB_ENTRIES(64)) dut (
    .clk(clk), .rstn(rstn),
    .lookup_valid(lookup_valid), .lookup_pc(lookup_pc),
    .hit(hit), .target(target),
    .update_valid(update_valid), .update_pc(update_pc),
    .update_taken(update_taken), .update_target(update_target),
    .invalidate(invalidate)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    lookup_valid  = 1'b0;
    lookup_pc     = 32'h0;
    update_valid  = 1'b0;
    update_pc     = 32'h0;
    update_taken  = 1'b0;
    update_target = 32'h0;
    invalidate    = 1'b0;
  endtask

  task automatic check(input string tag, input logic exp_hit, input logic [31:0] exp_tgt);
    total++;
    assert (hit === exp_hit) else begin
      bad++;
      $error("FAIL %s hit observed=%0b expected=%0b", tag, hit, exp_hit);
    end
    total++;
    assert (target === exp_tgt) else begin
      bad++;
      $error("FAIL %s target observed=%h expected=%h", tag, target, exp_tgt);
    end
  endtask

  task automatic upd(input logic [31:0] pc, input logic taken, input logic [31:0] tgt);
    update_valid  = 1'b1;
    update_pc     = pc;
    update_taken  = taken;
    update_target = tgt;
    cyc();
    idle();
  endtask

  task automatic look(input string tag, input logic [31:0] pc, input logic exp_hit, input logic [31:0] exp_tgt);
    lookup_valid = 1'b1;
    lookup_pc    = pc;
    cyc();
    check(tag, exp_hit, exp_tgt);
    idle();
  endtask

  initial begin
    idle();
    rstn = 1'b0;
    lookup_valid = 1'b1;
    lookup_pc    = 32'h1000;
    cyc();
    cyc();
    check("reset", 1'b0, 32'h0);
    idle();
    rstn = 1'b1;

    look("empty_1000", 32'h1000, 1'b0, 32'h0);

    upd(32'h1000, 1'b1, 32'h2004);
    look("hit_1000", 32'h1000, 1'b1, 32'h2004);
    look("hit_1002_lowbits", 32'h1002, 1'b1, 32'h2004);
    look("miss_other_index", 32'h1004, 1'b0, 32'h0);

    // 0x1000 and 0x1100 share index 0 with different tags
    upd(32'h1000, 1'b1, 32'h100);
    upd(32'h1100, 1'b1, 32'h200);
    look("alias_1000_evicted", 32'h1000, 1'b0, 32'h0);
    look("alias_1100", 32'h1100, 1'b1, 32'h200);

    upd(32'h1000, 1'b1, 32'h100);
    upd(32'h1000, 1'b0, 32'h0);
    look("nt_clears", 32'h1000, 1'b0, 32'h0);
    upd(32'h1000, 1'b1, 32'h107);
    look("tgt_low_forced", 32'h1000, 1'b1, 32'h104);
    upd(32'h1100, 1'b0, 32'h0);
    look("nt_other_tag_keeps", 32'h1000, 1'b1, 32'h104);

    lookup_valid = 1'b0;
    lookup_pc    = 32'h1000;
    cyc();
    check("lookup_valid_low", 1'b0, 32'h0);
    idle();

    upd(32'h2008, 1'b1, 32'hA000);
    upd(32'h300C, 1'b1, 32'hB000);
    upd(32'h4010, 1'b1, 32'hC000);
    look("pre_inv_2008", 32'h2008, 1'b1, 32'hA000);
    invalidate    = 1'b1;
    update_valid  = 1'b1;
    update_pc     = 32'h3000;
    update_taken  = 1'b1;
    update_target = 32'hD000;
    cyc();
    idle();
    look("inv_1000", 32'h1000, 1'b0, 32'h0);
    look("inv_2008", 32'h2008, 1'b0, 32'h0);
    look("inv_300C", 32'h300C, 1'b0, 32'h0);
    look("inv_4010", 32'h4010, 1'b0, 32'h0);
    look("inv_3000_dropped", 32'h3000, 1'b0, 32'h0);

    lookup_valid  = 1'b1;
    lookup_pc     = 32'h4000;
    update_valid  = 1'b1;
    update_pc     = 32'h4000;
    update_taken  = 1'b1;
    update_target = 32'h8000;
    cyc();
`ifdef RIP_BTB_BYPASS_EN
    check("same_cycle_upd", 1'b1, 32'h8000);
`else
    check("same_cycle_upd", 1'b0, 32'h0);
`endif
    idle();
    look("after_same_cycle", 32'h4000, 1'b1, 32'h8000);

    // lookup concurrent with invalidate
    lookup_valid = 1'b1;
    lookup_pc    = 32'h4000;
    invalidate   = 1'b1;
    cyc();
`ifdef RIP_BTB_BYPASS_EN
    check("lookup_with_inv", 1'b0, 32'h0);
`else
    check("lookup_with_inv", 1'b1, 32'h8000);
`endif
    idle();
    look("after_inv_4000", 32'h4000, 1'b0, 32'h0);

    upd(32'h4000, 1'b1, 32'h8000);
    look("reinstall_4000", 32'h4000, 1'b1, 32'h8000);
    rstn          = 1'b0;
    lookup_valid  = 1'b1;
    lookup_pc     = 32'h4000;
    update_valid  = 1'b1;
    update_pc     = 32'h5000;
    update_taken  = 1'b1;
    update_target = 32'h9000;
    cyc();
    check("midstream_reset", 1'b0, 32'h0);
    idle();
    rstn = 1'b1;
    look("post_reset_4000", 32'h4000, 1'b0, 32'h0);
    look("post_reset_5000", 32'h5000, 1'b0, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
